// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared constants, channel flag struct and half-period helper for clock_div_prog
package clock_div_pkg;
    localparam int CNT_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 256;
    typedef struct packed {
        logic pending;
        logic div_clk;
        logic rise;
        logic fall;
    } chan_flags_t;
    function automatic logic [31:0] half_ceil(input logic [31:0] d);
        return (d >> 1) + {31'b0, d[0]};
    endfunction
endpackage

// File: rtl/clock_div_chan.sv
// clock_div_chan: one programmable divider channel with shadowed divisor and edge strobes
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pending,
    output logic             div_clk,
    output logic             rising_edge,
    output logic             falling_edge,
    output logic             active
);
    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, sh_q, sh_d, nd, nxt, h;
    chan_flags_t      f_q, f_d;
    logic             wrap, apply;

    // next state: advance, wrap/sync restart, shadow apply and disable handling
    always_comb begin
        active = div_q >= CNT_W'(2);
        wrap = cnt_q == div_q - CNT_W'(1);
        apply = f_q.pending & (active ? en & (sync | wrap) : 1'b1);
        nd = apply ? sh_q : div_q;
        nxt = (sync | wrap) ? '0 : cnt_q + CNT_W'(1);
        h = CNT_W'(half_ceil(32'(nd)));
        div_d = nd;
        sh_d = wr ? wr_div : sh_q;
        f_d.pending = wr | (f_q.pending & ~apply);
        f_d.rise = 1'b0;
        f_d.fall = 1'b0;
        f_d.div_clk = f_q.div_clk;
        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = (apply && nd >= CNT_W'(2)) ? nd - CNT_W'(1) : '0;
            f_d.div_clk = 1'b0;
        end else if (en) begin
            cnt_d = (nd < CNT_W'(2)) ? '0 : nxt;
            f_d.div_clk = (nd >= CNT_W'(2)) && (nxt < h);
            f_d.rise = (nd >= CNT_W'(2)) && (nxt == '0);
            f_d.fall = (nd >= CNT_W'(2)) && (nxt == h);
        end
    end

    // channel state register, async reset to the default divisor just before wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_W'(DEFAULT_DIV - 1);
            div_q <= CNT_W'(DEFAULT_DIV);
            sh_q  <= CNT_W'(DEFAULT_DIV);
            f_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            sh_q  <= sh_d;
            f_q   <= f_d;
        end
    end

    assign pending      = f_q.pending;
    assign div_clk      = f_q.div_clk;
    assign rising_edge  = f_q.rise;
    assign falling_edge = f_q.fall;
endmodule

// File: rtl/clock_div_prog.sv
// clock_div_prog: multi-channel runtime-programmable clock divider and edge-strobe generator
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter  int NUM_CH      = 3,
    parameter  int CNT_W       = CNT_W_DEF,
    parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] rising_edge,
    output logic [NUM_CH-1:0] falling_edge,
    output logic [NUM_CH-1:0] active
);
    logic [NUM_CH-1:0]    pending;
    logic [2**CH_W-1:0]   pend_x;

    // out-of-range channels read as never pending so their writes are always accepted
    always_comb begin
        pend_x = (2**CH_W)'(pending);
        cfg_ready = ~pend_x[cfg_ch];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clock_div_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .sync         (sync),
            .wr           (cfg_valid & cfg_ready & (cfg_ch == CH_W'(c))),
            .wr_div       (cfg_div),
            .pending      (pending[c]),
            .div_clk      (div_clk[c]),
            .rising_edge  (rising_edge[c]),
            .falling_edge (falling_edge[c]),
            .active       (active[c])
        );
    end
endmodule

// File: tb/tb_clock_div_prog.sv
// tb_clock_div_prog: directed and randomized checks of clock_div_prog against a behavioural model
module tb_clock_div_prog;
    localparam int N  = 3;
    localparam int W  = 16;
    localparam int DD = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, sync = 1'b0, cfg_valid = 1'b0;
    logic [1:0]   cfg_ch = '0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready;
    logic [N-1:0] div_clk, rising_edge, falling_edge, active;

    int tests = 0;
    int fails = 0;
    int pos[N], dv[N], sh[N];
    bit pend[N], eclk[N], er[N], ef[N];

    clock_div_prog #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(DD)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sync         (sync),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .div_clk      (div_clk),
        .rising_edge  (rising_edge),
        .falling_edge (falling_edge),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            dv[c] = DD; pos[c] = DD - 1; sh[c] = DD; pend[c] = 0;
            eclk[c] = 0; er[c] = 0; ef[c] = 0;
        end
    endfunction

    function automatic bit exp_ready();
        return (int'(cfg_ch) >= N) || !pend[cfg_ch];
    endfunction

    // one system-clock cycle of the divider as described by its rules
    function automatic void model_step();
        bit acc = cfg_valid && exp_ready();
        for (int c = 0; c < N; c++) begin
            if (dv[c] >= 2) begin
                er[c] = 0; ef[c] = 0;
                if (en) begin
                    if (sync || pos[c] == dv[c] - 1) begin
                        if (pend[c]) begin dv[c] = sh[c]; pend[c] = 0; end
                        pos[c] = 0;
                        eclk[c] = dv[c] >= 2;
                        er[c] = dv[c] >= 2;
                    end else begin
                        pos[c]++;
                        eclk[c] = pos[c] < (dv[c] + 1) / 2;
                        ef[c] = pos[c] == (dv[c] + 1) / 2;
                    end
                end
            end else begin
                if (pend[c]) begin
                    dv[c] = sh[c]; pend[c] = 0;
                    pos[c] = dv[c] >= 2 ? dv[c] - 1 : 0;
                end
                eclk[c] = 0; er[c] = 0; ef[c] = 0;
            end
        end
        if (acc && int'(cfg_ch) < N) begin
            sh[cfg_ch] = int'(cfg_div);
            pend[cfg_ch] = 1;
        end
    endfunction

    task automatic check_outs();
        logic [N-1:0] xc, xr, xf, xa;
        for (int c = 0; c < N; c++) begin
            xc[c] = eclk[c]; xr[c] = er[c]; xf[c] = ef[c]; xa[c] = dv[c] >= 2;
        end
        check("div_clk", 32'(div_clk), 32'(xc));
        check("rising_edge", 32'(rising_edge), 32'(xr));
        check("falling_edge", 32'(falling_edge), 32'(xf));
        check("active", 32'(active), 32'(xa));
    endtask

    task automatic drive(input bit e, input bit s, input bit v, input int ch, input int d);
        @(negedge clk);
        check_outs();
        en = e; sync = s; cfg_valid = v; cfg_ch = 2'(ch); cfg_div = W'(d);
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
        @(posedge clk);
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) drive(1, 0, 0, 0, 0);
    endtask

    task automatic write_until_accepted(input int ch, input int d);
        int guard = 0;
        bit done = 0;
        while (!done && guard < 600) begin
            done = exp_ready();
            drive(1, 0, 1, ch, d);
            guard++;
        end
        check("write_accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        en = 0; sync = 0; cfg_valid = 0;
        rst = 1;
        #1;
        model_reset();
        check_outs();
        check("cfg_ready_rst", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_outs();
        check("cfg_ready_rst", 32'(cfg_ready), 32'd1);
        rst = 0;
        @(posedge clk);
        model_step();
        run(300);
        write_until_accepted(1, 5);
        repeat (4) drive(1, 0, 1, 1, 9);
        run(300);
        write_until_accepted(2, 0);
        run(300);
        write_until_accepted(2, 4);
        run(20);
        repeat (10) drive(0, 0, 0, 0, 0);
        run(300);
        write_until_accepted(0, 7);
        write_until_accepted(1, 4);
        run(300);
        drive(1, 1, 0, 0, 0);
        run(30);
        write_until_accepted(0, 3);
        drive(1, 1, 0, 0, 0);
        run(20);
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 1, 3, 2);
        run(20);
        for (int i = 0; i < 3000; i++) begin
            int k = $urandom_range(0, 9);
            int d = k == 0 ? 0 : k == 1 ? 1 : $urandom_range(2, 12);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3), d);
        end
        run(10);
        reset_pulse();
        run(300);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/clock_div_prog.md
Name: clock_div_prog

Overview:
- Multi-channel, runtime-programmable integer clock divider and edge-strobe generator for the audio datapath (MCLK/BCLK/LRCLK-style enables).
- Successor to the fixed power-of-two divider: any divisor ≥2, per-channel ratio, glitch-free ratio change at period boundary, global enable and phase-align sync.
- Sits in util/, driven by the system clock; consumers use the strobes as clock enables rather than clocking on div_clk.

Parameters:
- NUM_CH, 3, number of independent divider channels (≥1).
- CNT_W, 16, counter/divisor width; max divisor 2^CNT_W-1.
- DEFAULT_DIV, 256, divisor loaded into every channel at reset; must fit CNT_W and be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  global advance enable.
- sync  in  1  one-cycle pulse; restarts all active channels in phase.
- cfg_valid  in  1  divisor write request.
- cfg_ready  out  1  write accepted when cfg_valid & cfg_ready.
- cfg_ch  in  CH_W = max(1,$clog2(NUM_CH))  target channel.
- cfg_div  in  CNT_W  new divisor D; D<2 disables the channel.
- div_clk  out  NUM_CH  divided clock level per channel.
- rising_edge  out  NUM_CH  one-cycle strobe, first cycle of high phase.
- falling_edge  out  NUM_CH  one-cycle strobe, first cycle of low phase.
- active  out  NUM_CH  channel running (current D ≥2).

Behaviour:
- Per channel state: count[CNT_W], cur_div, shadow_div, pending, registered div_clk/rising/falling.
- H = ceil(cur_div/2). Period = D cycles, high H cycles, low D-H. Examples: D=2 → 1/1; D=3 → 2/1.
- Reset: count=DEFAULT_DIV-1, cur_div=DEFAULT_DIV, pending=0, active=1.
  - div_clk, rising_edge and falling_edge are 0; cfg_ready=1.
- Advance (en=1, active): next = (count==cur_div-1) ? 0 : count+1.
  - Registered outputs: div_clk <= (next<H), rising <= (next==0), falling <= (next==H).
  - First enabled cycle after reset gives next=0, so rising pulses one cycle after en rises.
- en=0: count and div_clk hold; strobes <= 0. Periods stretch by the disabled cycles; no duplicate strobes on re-enable.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] (combinational). cfg_ch ≥ NUM_CH: ready=1, write accepted and discarded.
  - Accepted write sets shadow_div and pending.
- Shadow apply:
  - Active channel: at the wrap advance (count==cur_div-1, en=1), cur_div <= shadow, pending <= 0, and next period runs at new D from count 0.
  - If the new D<2, the channel disables at that boundary: count=0, div_clk=0, strobes 0, active=0.
  - Inactive channel: apply on the clock edge after acceptance regardless of en; count <= D-1, so the next enabled advance produces rising.
- sync=1 with en=1:
  - Every channel applies any pending shadow.
  - Active channels force next=0: rising=1, div_clk=1 the following cycle, all channels aligned.
  - sync has priority over normal wrap. sync with en=0 is ignored.
- Same-cycle accept and apply on the same channel cannot occur (ready low while pending).
- rst mid-operation: immediate return to reset values; pending writes lost.

Decomposition:
- Package clock_div_pkg: default CNT_W, DEFAULT_DIV constant, function half_ceil(D), channel-state struct typedef.
- Sub-module clock_div_chan: one channel (counter, shadow, outputs).
- Top clock_div_prog: cfg demux and cfg_ready mux, generate loop over NUM_CH, broadcast of en/sync.

Test Plan:
- Reset, en=1 at cycle 0, defaults → ch0 rising at cycle 1, falling at cycle 129, next rising at cycle 257; div_clk high 128 cycles.
- Write D=5 to ch1 at count 40 → cfg_ready for ch1 low until wrap; next periods high 3, low 2, rising every 5 cycles; second write while pending stalls.
- Write D=0 to ch2 → disables at boundary (active=0, div_clk=0). Write D=4 → starts next cycle; rising after first enabled advance, then period 4.
- en low for 10 cycles at ch0 count 3 → outputs frozen, no strobes, period measures 266.
- ch0 D=7, ch1 D=4 free-running; pulse sync → both rising in the next cycle, then periods 7/4 from that aligned edge. With a pending shadow present, sync applies it.
- Out-of-range cfg_ch=3 (NUM_CH=3) → accepted, no channel changes. Assert rst mid-period → all outputs 0 immediately, sequence repeats the first scenario.
